sgbm_frame_writer: RTL and testbench
====================================

Name: sgbm_frame_writer

Overview:
Parametrised successor to the single-frame disparity-to-BRAM writer. Takes the raster-ordered disparity stream from the SGBM core and writes each frame into one of NUM_BUF consecutive buffers in an AXI-BRAM-controller-style port. The PS consumes buffers through a level interrupt plus acknowledge. Adds multi-frame ping-pong operation, frame-sync checking and dropped-frame accounting.

Parameters:
IMG_W, 400, pixels per row
IMG_H, 200, rows per frame
COORD_W, 10, width of row_in/col_in
DATA_W, 32, disparity/RAM data width (multiple of 8)
ADDR_W, 32, RAM address width
BASE_ADDR, 0, address of buffer 0
ADDR_STEP, 1, address increment per pixel (4 for byte addressing)
NUM_BUF, 2, number of frame buffers (1..8); BUF_W = max(1, clog2(NUM_BUF))

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
disparity  in  DATA_W  pixel value
row_in  in  COORD_W  pixel row
col_in  in  COORD_W  pixel column
valid  in  1  pixel qualifier, one pixel per cycle max
intr_ack  in  1  one-cycle pulse from PS: release oldest published buffer
ram_clk  out  1  equals clk
ram_rd_data  in  DATA_W  unused, kept for port compatibility
ram_en  out  1  write enable strobe
ram_addr  out  ADDR_W  write address
ram_we  out  DATA_W/8  byte enables
ram_wr_data  out  DATA_W  write data
ram_rst  out  1  RAM port reset
intr  out  1  level: at least one buffer published and not yet acked
done_buf  out  BUF_W  index of oldest published buffer
drop_cnt  out  16  frames discarded for lack of a free buffer, saturating
sync_err  out  1  sticky: coordinate mismatch seen

Behaviour:
- Reset values: ram_en=0, ram_addr=0, ram_we=0, ram_wr_data=0, ram_rst=1, intr=0, done_buf=0, drop_cnt=0, sync_err=0. Also wr_buf=0, pending mask=0, state=IDLE. ram_rst drops to 0 on the first cycle after rst deasserts.
- A reset mid-frame abandons the frame and clears all pending buffers.
- Internal counters: pix_cnt (pixel index), exp_row, exp_col.
- Buffer b base address = BASE_ADDR + b*IMG_W*IMG_H*ADDR_STEP.
- States:
  - IDLE: valid pixels ignored unless row_in=0 and col_in=0.
  - On (0,0): if buffer wr_buf is not pending, write it and go to WRITE. Otherwise increment drop_cnt and go to DROP.
  - WRITE: every valid pixel is written.
  - DROP: valid pixels discarded; return to IDLE after pixel (IMG_H-1, IMG_W-1).
- Write timing: 1-cycle latency. The cycle after an accepted pixel: ram_en=1, ram_we=all ones, ram_wr_data=disparity, ram_addr=base(wr_buf)+pix_cnt*ADDR_STEP. ram_en and ram_we are 0 in every cycle without an accepted pixel.
- Sync check in WRITE: row_in/col_in must equal exp_row/exp_col. On mismatch: pixel not written, sync_err set (sticky until rst), buffer not published, state to IDLE.
  - A mismatching pixel that is (0,0) is not re-evaluated as a new frame start in that cycle.
- Publish: pixel (IMG_H-1, IMG_W-1) is written normally. In the same cycle, pending[wr_buf] is set, wr_buf advances modulo NUM_BUF, and state goes to IDLE.
- intr = OR of pending, registered, so it rises 1 cycle after the last pixel's write strobe.
- done_buf = oldest pending index; publish order is kept in a FIFO of depth NUM_BUF.
- intr_ack: clears the oldest pending bit. Ignored when nothing is pending.
- An ack and a publish in the same cycle both take effect.
- An ack can free wr_buf in the same cycle a (0,0) arrives. The frame is still dropped, because the decision uses the pending state before the update.
- drop_cnt saturates at 0xFFFF.
- valid with row_in >= IMG_H or col_in >= IMG_W: in WRITE this is a mismatch; otherwise ignored.

Test Plan:
Test parameters: IMG_W=4, IMG_H=2, NUM_BUF=2, ADDR_STEP=4, BASE_ADDR=0x1000, DATA_W=32.
- Reset then one clean frame, pixels 1..8 consecutive -> ram_en pulses at addresses 0x1000,0x1004,...,0x101C with data 1..8, ram_we=0xF. intr rises 1 cycle after the last strobe; done_buf=0.
- Second frame with no ack -> writes at 0x1020..0x103C, intr stays high, done_buf=0. Ack -> done_buf=1, intr still 1. Second ack -> intr=0.
- Third frame while both buffers are pending -> no ram_en, drop_cnt=1. Ack, then fourth frame -> written at 0x1000..0x101C.
- Gapped valid (pixel every 3rd cycle) and pixels preceding (0,0) -> leading pixels ignored; strobes only for accepted pixels; addresses contiguous.
- Mid-frame jump from (0,1) to (1,0) -> sync_err=1, no publish, intr stays 0. Next clean frame is written to buffer 0 at 0x1000 and published.
- rst asserted after 5 pixels of a frame -> all outputs return to reset values the next cycle. A following frame is written from 0x1000.

Source files
------------

// File: rtl/sgbm_frame_writer.sv
// rtl/sgbm_frame_writer.sv - raster disparity stream to NUM_BUF ping-pong RAM frame buffers
module sgbm_frame_writer #(
  parameter int                IMG_W     = 400,
  parameter int                IMG_H     = 200,
  parameter int                COORD_W   = 10,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ADDR_STEP = 1,
  parameter int                NUM_BUF   = 2,
  parameter int                BUF_W     = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [DATA_W-1:0]   i_disparity,
  input  logic [COORD_W-1:0]  i_row_in,
  input  logic [COORD_W-1:0]  i_col_in,
  input  logic                i_valid,
  input  logic                i_intr_ack,
  output logic                o_ram_clk,
  input  logic [DATA_W-1:0]   i_ram_rd_data,
  output logic                o_ram_en,
  output logic [ADDR_W-1:0]   o_ram_addr,
  output logic [DATA_W/8-1:0] o_ram_we,
  output logic [DATA_W-1:0]   o_ram_wr_data,
  output logic                o_ram_rst,
  output logic                o_intr,
  output logic [BUF_W-1:0]    o_done_buf,
  output logic [15:0]         o_drop_cnt,
  output logic                o_sync_err
);

  localparam int PIX_W      = $clog2(IMG_W * IMG_H + 1);
  localparam int CNT_W      = $clog2(NUM_BUF + 1);
  localparam int FRAME_SPAN = IMG_W * IMG_H * ADDR_STEP;
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;

  state_t               r_state, w_state_next;
  logic [PIX_W-1:0]     r_pix_cnt;
  logic [COORD_W-1:0]   r_exp_row, r_exp_col;
  logic [BUF_W-1:0]     r_wr_buf;
  logic [NUM_BUF-1:0]   r_pending, w_pending_next;
  logic [BUF_W-1:0]     r_fifo [NUM_BUF];
  logic [BUF_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ram_en, r_ram_rst, r_intr, r_sync_err;
  logic [ADDR_W-1:0]    r_ram_addr;
  logic [DATA_W/8-1:0]  r_ram_we;
  logic [DATA_W-1:0]    r_ram_wr_data;
  logic [15:0]          r_drop_cnt;

  logic w_origin, w_last, w_match, w_free, w_ack;
  logic w_write, w_publish, w_drop_start, w_sync_fail;
  logic [PIX_W-1:0]  w_pix_idx;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused;

  function automatic logic [BUF_W-1:0] f_inc(input logic [BUF_W-1:0] v);
    f_inc = (v == BUF_W'(NUM_BUF - 1)) ? '0 : v + BUF_W'(1);
  endfunction

  assign w_unused  = ^i_ram_rd_data;
  assign w_origin  = (i_row_in == '0) && (i_col_in == '0);
  assign w_last    = (i_row_in == LAST_ROW) && (i_col_in == LAST_COL);
  assign w_match   = (i_row_in == r_exp_row) && (i_col_in == r_exp_col);
  assign w_free    = !r_pending[r_wr_buf];
  assign w_ack     = i_intr_ack && (r_count != '0);
  assign w_pix_idx = (r_state == S_IDLE) ? '0 : r_pix_cnt;
  assign w_addr    = BASE_ADDR + ADDR_W'(r_wr_buf) * ADDR_W'(FRAME_SPAN)
                   + ADDR_W'(w_pix_idx) * ADDR_W'(ADDR_STEP);

  // FSM state register; reset abandons any frame in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state: frame start, publish, sync loss and end of a dropped frame
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_write && !w_publish)          w_state_next = S_WRITE;
        else if (w_drop_start && !w_last)   w_state_next = S_DROP;
      end
      S_WRITE: if (w_sync_fail || w_publish) w_state_next = S_IDLE;
      S_DROP:  if (i_valid && w_last)        w_state_next = S_IDLE;
      default:                               w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: per-pixel accept/drop/mismatch decisions, using pre-ack pending state
  always_comb begin
    w_write      = 1'b0;
    w_drop_start = 1'b0;
    w_sync_fail  = 1'b0;
    case (r_state)
      S_IDLE: if (i_valid && w_origin) begin
        if (w_free) w_write      = 1'b1;
        else        w_drop_start = 1'b1;
      end
      S_WRITE: if (i_valid) begin
        if (w_match) w_write     = 1'b1;
        else         w_sync_fail = 1'b1;
      end
      default: ;
    endcase
    w_publish = w_write && w_last;
  end

  // Write port, expected-coordinate tracking and status flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ram_en      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_we      <= '0;
      r_ram_wr_data <= '0;
      r_ram_rst     <= 1'b1;
      r_intr        <= 1'b0;
      r_drop_cnt    <= '0;
      r_sync_err    <= 1'b0;
      r_pix_cnt     <= '0;
      r_exp_row     <= '0;
      r_exp_col     <= '0;
    end else begin
      r_ram_rst <= 1'b0;
      r_ram_en  <= w_write;
      r_ram_we  <= w_write ? '1 : '0;
      r_intr    <= |r_pending;
      if (w_write) begin
        r_ram_addr    <= w_addr;
        r_ram_wr_data <= i_disparity;
        r_pix_cnt     <= w_pix_idx + PIX_W'(1);
        if (i_col_in == LAST_COL) begin
          r_exp_col <= '0;
          r_exp_row <= i_row_in + COORD_W'(1);
        end else begin
          r_exp_col <= i_col_in + COORD_W'(1);
          r_exp_row <= i_row_in;
        end
      end
      if (w_drop_start && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_sync_fail) r_sync_err <= 1'b1;
    end
  end

  // Pending mask next value: publish sets the written buffer, ack clears the oldest
  always_comb begin
    w_pending_next = r_pending;
    if (w_publish) w_pending_next[r_wr_buf] = 1'b1;
    if (w_ack)     w_pending_next[r_fifo[r_rd_ptr]] = 1'b0;
  end

  // Buffer ownership: write pointer and publish-order FIFO
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending <= '0;
      r_wr_buf  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      for (int i = 0; i < NUM_BUF; i++) r_fifo[i] <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (w_publish) begin
        r_fifo[r_wr_ptr] <= r_wr_buf;
        r_wr_ptr         <= f_inc(r_wr_ptr);
        r_wr_buf         <= f_inc(r_wr_buf);
      end
      if (w_ack) r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_publish && !w_ack)      r_count <= r_count + CNT_W'(1);
      else if (!w_publish && w_ack) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_ram_clk     = i_clk;
  assign o_ram_en      = r_ram_en;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_we      = r_ram_we;
  assign o_ram_wr_data = r_ram_wr_data;
  assign o_ram_rst     = r_ram_rst;
  assign o_intr        = r_intr;
  assign o_done_buf    = r_fifo[r_rd_ptr];
  assign o_drop_cnt    = r_drop_cnt;
  assign o_sync_err    = r_sync_err;

endmodule

// File: tb/tb_sgbm_frame_writer.sv
// tb/tb_sgbm_frame_writer.sv - self-checking bench for sgbm_frame_writer
module tb_sgbm_frame_writer;

  localparam int W = 4, H = 2, NB = 2, STEP = 4, DW = 32, AW = 32, CW = 10, BW = 1;
  localparam logic [31:0] BASE = 32'h1000;

  logic          i_clk, i_rst, i_valid, i_intr_ack;
  logic [DW-1:0] i_disparity, i_ram_rd_data;
  logic [CW-1:0] i_row_in, i_col_in;
  logic          o_ram_clk, o_ram_en, o_ram_rst, o_intr, o_sync_err;
  logic [AW-1:0] o_ram_addr;
  logic [DW/8-1:0] o_ram_we;
  logic [DW-1:0] o_ram_wr_data;
  logic [BW-1:0] o_done_buf;
  logic [15:0]   o_drop_cnt;

  sgbm_frame_writer #(
    .IMG_W(W), .IMG_H(H), .COORD_W(CW), .DATA_W(DW), .ADDR_W(AW),
    .BASE_ADDR(BASE), .ADDR_STEP(STEP), .NUM_BUF(NB), .BUF_W(BW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_disparity(i_disparity), .i_row_in(i_row_in),
    .i_col_in(i_col_in), .i_valid(i_valid), .i_intr_ack(i_intr_ack),
    .o_ram_clk(o_ram_clk), .i_ram_rd_data(i_ram_rd_data), .o_ram_en(o_ram_en),
    .o_ram_addr(o_ram_addr), .o_ram_we(o_ram_we), .o_ram_wr_data(o_ram_wr_data),
    .o_ram_rst(o_ram_rst), .o_intr(o_intr), .o_done_buf(o_done_buf),
    .o_drop_cnt(o_drop_cnt), .o_sync_err(o_sync_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // reference model: frame-level view of buffers and the stream
  int m_mode;        // 0 waiting for frame start, 1 storing, 2 discarding
  int m_wr_buf;
  int m_next_idx;
  int m_drop;
  bit m_sync;
  int m_pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wr_buf = 0; m_next_idx = 0; m_drop = 0; m_sync = 0;
    m_pend.delete();
  endtask

  task automatic rst_dut();
    i_rst = 1'b1; i_valid = 1'b0; i_intr_ack = 1'b0;
    @(posedge i_clk); @(negedge i_clk);
    chk("rst_ram_en", 32'(o_ram_en), 32'h0);
    chk("rst_ram_addr", o_ram_addr, 32'h0);
    chk("rst_ram_we", 32'(o_ram_we), 32'h0);
    chk("rst_ram_wr_data", o_ram_wr_data, 32'h0);
    chk("rst_ram_rst", 32'(o_ram_rst), 32'h1);
    chk("rst_intr", 32'(o_intr), 32'h0);
    chk("rst_done_buf", 32'(o_done_buf), 32'h0);
    chk("rst_drop_cnt", 32'(o_drop_cnt), 32'h0);
    chk("rst_sync_err", 32'(o_sync_err), 32'h0);
    i_rst = 1'b0;
    model_reset();
  endtask

  // one clock: drive at negedge, predict, check at the following negedge
  task automatic cycle(input bit v, input int r, input int c, input logic [31:0] d, input bit ack);
    bit exp_en = 0;
    bit had, busy;
    int idx;
    logic [31:0] exp_addr = 32'h0;
    i_valid = v; i_row_in = r[CW-1:0]; i_col_in = c[CW-1:0];
    i_disparity = d; i_intr_ack = ack;
    had = (m_pend.size() != 0);
    busy = 0;
    foreach (m_pend[k]) if (m_pend[k] == m_wr_buf) busy = 1;
    idx = r * W + c;
    case (m_mode)
      0: if (v && r == 0 && c == 0) begin
        if (!busy) begin
          exp_en = 1; exp_addr = BASE + 32'(m_wr_buf * W * H * STEP);
          m_next_idx = 1; m_mode = (W * H == 1) ? 0 : 1;
        end else begin
          if (m_drop < 65535) m_drop++;
          m_mode = 2;
        end
      end
      1: if (v) begin
        if (r < H && c < W && idx == m_next_idx) begin
          exp_en = 1; exp_addr = BASE + 32'(m_wr_buf * W * H * STEP + idx * STEP);
          m_next_idx++;
          if (idx == W * H - 1) begin
            m_pend.push_back(m_wr_buf);
            m_wr_buf = (m_wr_buf + 1) % NB;
            m_mode = 0;
          end
        end else begin
          m_sync = 1; m_mode = 0;
        end
      end
      default: if (v && r == H - 1 && c == W - 1) m_mode = 0;
    endcase
    if (ack && had) void'(m_pend.pop_front());
    @(posedge i_clk); @(negedge i_clk);
    chk("ram_en", 32'(o_ram_en), 32'(exp_en));
    chk("ram_we", 32'(o_ram_we), exp_en ? 32'hF : 32'h0);
    if (exp_en) begin
      chk("ram_addr", o_ram_addr, exp_addr);
      chk("ram_wr_data", o_ram_wr_data, d);
    end
    chk("intr", 32'(o_intr), 32'(had));
    chk("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
    chk("sync_err", 32'(o_sync_err), 32'(m_sync));
    chk("ram_rst", 32'(o_ram_rst), 32'h0);
    if (m_pend.size() != 0) chk("done_buf", 32'(o_done_buf), 32'(m_pend[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, $urandom_range(0, 3), $urandom_range(0, 5), $urandom, 0);
  endtask

  task automatic ack_cycle();
    cycle(0, 0, 0, $urandom, 1);
  endtask

  task automatic frame(input int gap, input bit ack_last, input bit seq_data);
    for (int i = 0; i < W * H; i++) begin
      cycle(1, i / W, i % W, seq_data ? 32'(i + 1) : $urandom, ack_last && (i == W * H - 1));
      if (i != W * H - 1) idle(gap);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_intr_ack = 1'b0; i_disparity = '0;
    i_row_in = '0; i_col_in = '0; i_ram_rd_data = '0;
    model_reset();
    @(negedge i_clk);
    rst_dut();

    // clean frame, data 1..8, into buffer 0
    frame(0, 0, 1);
    idle(1);
    chk("f1_intr", 32'(o_intr), 32'h1);
    chk("f1_done_buf", 32'(o_done_buf), 32'h0);

    // second frame, no ack, into buffer 1
    frame(0, 0, 0);
    idle(2);
    chk("f2_done_buf", 32'(o_done_buf), 32'h0);

    // third frame dropped while both buffers pending
    frame(0, 0, 0);
    idle(2);
    chk("f3_drop_cnt", 32'(o_drop_cnt), 32'h1);
    ack_cycle(); idle(1);
    chk("ack1_done_buf", 32'(o_done_buf), 32'h1);
    chk("ack1_intr", 32'(o_intr), 32'h1);
    ack_cycle(); idle(2);
    chk("ack2_intr", 32'(o_intr), 32'h0);
    ack_cycle(); idle(1);

    // fourth/fifth frames fill both buffers; ack coinciding with frame start still drops
    frame(0, 0, 0);
    frame(1, 0, 0);
    idle(1);
    cycle(1, 0, 0, $urandom, 1);
    for (int i = 1; i < W * H; i++) cycle(1, i / W, i % W, $urandom, 0);
    idle(2);
    chk("ackstart_drop_cnt", 32'(o_drop_cnt), 32'h2);
    ack_cycle(); idle(2);

    // leading junk before frame start, then gapped frame with ack on the last pixel
    cycle(1, 1, 2, $urandom, 0);
    cycle(1, 0, 3, $urandom, 0);
    cycle(1, 5, 9, $urandom, 0);
    frame(2, 0, 0);
    idle(2);
    frame(2, 1, 0);
    idle(2);
    ack_cycle(); ack_cycle(); idle(2);

    // sync loss mid-frame, then a clean frame to buffer 0
    rst_dut();
    cycle(1, 0, 0, $urandom, 0);
    cycle(1, 0, 1, $urandom, 0);
    cycle(1, 1, 0, $urandom, 0);
    cycle(1, 1, 1, $urandom, 0);
    idle(2);
    chk("sync_err_set", 32'(o_sync_err), 32'h1);
    chk("sync_no_intr", 32'(o_intr), 32'h0);
    frame(0, 0, 0);
    idle(2);
    chk("sync_recover_intr", 32'(o_intr), 32'h1);

    // reset mid-frame, then a fresh frame from the first buffer
    ack_cycle();
    for (int i = 0; i < 5; i++) cycle(1, i / W, i % W, $urandom, 0);
    rst_dut();
    frame(1, 0, 0);
    idle(2);

    // randomized traffic with occasional coordinate corruption and random acks
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < W * H; i++) begin
        int r, c;
        r = i / W; c = i % W;
        if ($urandom_range(0, 15) == 0) begin
          r = $urandom_range(0, 2); c = $urandom_range(0, 4);
        end
        cycle(1, r, c, $urandom, $urandom_range(0, 7) == 0);
        repeat ($urandom_range(0, 2)) cycle(0, 0, 0, $urandom, $urandom_range(0, 3) == 0);
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
